// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity checker: FSM state encoding and
// the frame bit-counter width.
package serial_parity_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // A single-bit frame still needs a one-bit counter.
   function automatic int cnt_width(input int data_bits);
      return (data_bits <= 1) ? 1 : $clog2(data_bits);
   endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Frame handshake and result bundle between a bit source/result consumer
// (master) and the serial parity checker (slave).
interface serial_parity_checker_if #(
   parameter int DATA_BITS = 8
);
   logic                 start;
   logic                 abort;
   logic                 bit_in;
   logic                 bit_valid;
   logic                 bit_ready;
   logic                 busy;
   logic                 done;
   logic                 ack;
   logic                 parity_ok;
   logic [DATA_BITS-1:0] data_out;

   modport master (
      output start, abort, bit_in, bit_valid, ack,
      input  bit_ready, busy, done, parity_ok, data_out
   );

   modport slave (
      input  start, abort, bit_in, bit_valid, ack,
      output bit_ready, busy, done, parity_ok, data_out
   );
endinterface

// File: rtl/parity_acc.sv
// One-bit XOR accumulator: load takes priority over enable, otherwise it
// holds its value.
module parity_acc (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic load_value,
   input  logic enable,
   input  logic bit_in,
   output logic acc
);
   logic xor_next;

   xor_gate u_xor (
      .a (acc),
      .b (bit_in),
      .y (xor_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 1'b0;
      end else if (load) begin
         acc <= load_value;
      end else if (enable) begin
         acc <= xor_next;
      end
   end
endmodule

// File: rtl/xor_gate.sv
// Two-input XOR cell used as the next-state logic of the parity accumulator.
module xor_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

// File: rtl/serial_parity_checker.sv
// Bit-serial frame receiver: deserialises DATA_BITS data bits (LSB first),
// checks the trailing parity bit and holds the result until acknowledged.
module serial_parity_checker
   import serial_parity_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int ODD       = 0
) (
   input logic                   clk,
   input logic                   rst_n,
   serial_parity_checker_if.slave bus
);
   localparam int            CW   = cnt_width(DATA_BITS);
   localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [DATA_BITS-1:0] data_q;
   logic                 ready_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 ok_q;
   logic                 acc;
   logic                 xfer;
   logic                 acc_load;
   logic                 acc_en;

   assign xfer     = bus.bit_valid & ready_q;
   assign acc_load = (state == S_IDLE) & bus.start & ~bus.abort;
   assign acc_en   = (state == S_DATA) & xfer & ~bus.abort;

   // Seeding with ODD lets a zero final XOR mean "pass" for both parities.
   parity_acc u_acc (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (acc_load),
      .load_value (ODD != 0),
      .enable     (acc_en),
      .bit_in     (bus.bit_in),
      .acc        (acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  state   <= S_DATA;
                  cnt     <= '0;
                  data_q  <= '0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            // The counter stops on the last data bit so it never wraps.
            S_DATA: begin
               if (bus.abort) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (xfer) begin
                  data_q[cnt] <= bus.bit_in;
                  if (cnt == LAST) begin
                     state <= S_PARITY;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (bus.abort) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (xfer) begin
                  ok_q    <= ~(acc ^ bus.bit_in);
                  state   <= S_DONE;
                  ready_q <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.abort || bus.ack) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.bit_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.parity_ok = ok_q;
   assign bus.data_out  = data_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench: an even- and an odd-parity checker receive identical
// stimulus; expected results are queued per frame and compared at done.
module tb_serial_parity_checker;

   typedef struct {
      logic       ok_even;
      logic       ok_odd;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];

   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic start     = 1'b0;
   logic abort     = 1'b0;
   logic bit_in    = 1'b0;
   logic bit_valid = 1'b0;
   logic ack       = 1'b0;

   int checks = 0;
   int fails  = 0;

   serial_parity_checker_if #(.DATA_BITS(8)) bus_even ();
   serial_parity_checker_if #(.DATA_BITS(8)) bus_odd ();

   assign bus_even.start     = start;
   assign bus_even.abort     = abort;
   assign bus_even.bit_in    = bit_in;
   assign bus_even.bit_valid = bit_valid;
   assign bus_even.ack       = ack;
   assign bus_odd.start      = start;
   assign bus_odd.abort      = abort;
   assign bus_odd.bit_in     = bit_in;
   assign bus_odd.bit_valid  = bit_valid;
   assign bus_odd.ack        = ack;

   serial_parity_checker #(.DATA_BITS(8), .ODD(0)) dut_even (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_even)
   );

   serial_parity_checker #(.DATA_BITS(8), .ODD(1)) dut_odd (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_odd)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected result from first principles: XOR of all bits plus the ODD seed must be zero.
   task automatic push_expect(input logic [7:0] d, input logic par);
      exp_t e;
      e.data    = d;
      e.ok_even = ~((^d) ^ par);
      e.ok_odd  = ~(1'b1 ^ (^d) ^ par);
      sb.push_back(e);
   endtask

   // Starts a frame and sends 8 data bits plus parity; returns at the negedge after the parity transfer.
   task automatic drive_frame(input logic [7:0] d, input logic par, input bit gaps);
      int g;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      push_expect(d, par);
      for (int i = 0; i < 9; i++) begin
         if (gaps) begin
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
               bit_valid = 1'b0;
               bit_in    = 1'($urandom_range(0, 1));
               start     = 1'($urandom_range(0, 1));
               @(negedge clk);
            end
            start = 1'b0;
         end
         bit_valid = 1'b1;
         bit_in    = (i < 8) ? d[i] : par;
         @(negedge clk);
      end
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic send_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic test_reset();
      #7;
      checks++; if (bus_even.bit_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_bit_ready: got %b, want 0", bus_even.bit_ready); end
      checks++; if (bus_even.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, want 0", bus_even.busy); end
      checks++; if (bus_even.done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b, want 0", bus_even.done); end
      checks++; if (bus_even.parity_ok !== 1'b0) begin fails++; $display("[TB] FAIL reset_parity_ok: got %b, want 0", bus_even.parity_ok); end
      checks++; if (bus_even.data_out !== 8'h00) begin fails++; $display("[TB] FAIL reset_data_out: got %h, want 00", bus_even.data_out); end
      checks++; if (bus_odd.busy !== 1'b0 || bus_odd.done !== 1'b0) begin fails++; $display("[TB] FAIL reset_odd: busy=%b done=%b, want 0 0", bus_odd.busy, bus_odd.done); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus_even.busy !== 1'b0 || bus_even.bit_ready !== 1'b0) begin fails++; $display("[TB] FAIL idle_after_reset: busy=%b ready=%b, want 0 0", bus_even.busy, bus_even.bit_ready); end
   endtask

   task automatic test_even_pass();
      exp_t e;
      drive_frame(8'hA5, 1'b0, 1'b0);
      checks++; if (bus_even.done !== 1'b1) begin fails++; $display("[TB] FAIL pass_done_latency: got %b, want 1", bus_even.done); end
      checks++; if (bus_even.bit_ready !== 1'b0) begin fails++; $display("[TB] FAIL pass_ready_in_done: got %b, want 0", bus_even.bit_ready); end
      e = sb.pop_front();
      checks++; if (bus_even.parity_ok !== e.ok_even) begin fails++; $display("[TB] FAIL pass_ok_even: got %b, want %b", bus_even.parity_ok, e.ok_even); end
      checks++; if (bus_even.data_out !== e.data) begin fails++; $display("[TB] FAIL pass_data: got %h, want %h", bus_even.data_out, e.data); end
      checks++; if (bus_odd.parity_ok !== e.ok_odd) begin fails++; $display("[TB] FAIL pass_ok_odd: got %b, want %b", bus_odd.parity_ok, e.ok_odd); end
      send_ack();
      checks++; if (bus_even.done !== 1'b0 || bus_even.busy !== 1'b0) begin fails++; $display("[TB] FAIL pass_after_ack: done=%b busy=%b, want 0 0", bus_even.done, bus_even.busy); end
   endtask

   task automatic test_hold_until_ack();
      exp_t e;
      int   bad;
      drive_frame(8'hA5, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (bus_even.parity_ok !== e.ok_even) begin fails++; $display("[TB] FAIL hold_ok_even: got %b, want %b", bus_even.parity_ok, e.ok_even); end
      checks++; if (bus_odd.parity_ok !== e.ok_odd) begin fails++; $display("[TB] FAIL hold_ok_odd: got %b, want %b", bus_odd.parity_ok, e.ok_odd); end
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus_even.done !== 1'b1 || bus_even.parity_ok !== e.ok_even || bus_even.data_out !== e.data) bad++;
      end
      checks++; if (bad != 0) begin fails++; $display("[TB] FAIL hold_stable: %0d unstable cycles, want 0 (done=%b ok=%b data=%h)", bad, bus_even.done, bus_even.parity_ok, bus_even.data_out); end
      send_ack();
   endtask

   task automatic test_odd_parity();
      exp_t e;
      drive_frame(8'h01, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++; if (bus_odd.parity_ok !== e.ok_odd) begin fails++; $display("[TB] FAIL odd_p0_ok: got %b, want %b", bus_odd.parity_ok, e.ok_odd); end
      checks++; if (bus_even.parity_ok !== e.ok_even) begin fails++; $display("[TB] FAIL odd_p0_even_ok: got %b, want %b", bus_even.parity_ok, e.ok_even); end
      checks++; if (bus_odd.data_out !== e.data) begin fails++; $display("[TB] FAIL odd_p0_data: got %h, want %h", bus_odd.data_out, e.data); end
      send_ack();
      drive_frame(8'h01, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (bus_odd.parity_ok !== e.ok_odd) begin fails++; $display("[TB] FAIL odd_p1_ok: got %b, want %b", bus_odd.parity_ok, e.ok_odd); end
      checks++; if (bus_even.parity_ok !== e.ok_even) begin fails++; $display("[TB] FAIL odd_p1_even_ok: got %b, want %b", bus_even.parity_ok, e.ok_even); end
      send_ack();
   endtask

   task automatic test_gaps();
      exp_t e;
      int   n;
      drive_frame(8'hFF, 1'b0, 1'b1);
      n = 0;
      while (bus_even.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (bus_even.done !== 1'b1) begin fails++; $display("[TB] FAIL gaps_done_timeout: done=%b, want 1", bus_even.done); end
      e = sb.pop_front();
      checks++; if (bus_even.parity_ok !== e.ok_even) begin fails++; $display("[TB] FAIL gaps_ok_even: got %b, want %b", bus_even.parity_ok, e.ok_even); end
      checks++; if (bus_even.data_out !== e.data) begin fails++; $display("[TB] FAIL gaps_data: got %h, want %h", bus_even.data_out, e.data); end
      checks++; if (bus_odd.parity_ok !== e.ok_odd) begin fails++; $display("[TB] FAIL gaps_ok_odd: got %b, want %b", bus_odd.parity_ok, e.ok_odd); end
      send_ack();
   endtask

   task automatic test_abort();
      exp_t e;
      int   bad;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (bus_even.bit_ready !== 1'b1 || bus_even.busy !== 1'b1) begin fails++; $display("[TB] FAIL abort_in_data: ready=%b busy=%b, want 1 1", bus_even.bit_ready, bus_even.busy); end
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1;
         bit_in    = 1'b1;
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      checks++; if (bus_even.busy !== 1'b0 || bus_even.bit_ready !== 1'b0 || bus_even.done !== 1'b0) begin fails++; $display("[TB] FAIL abort_to_idle: busy=%b ready=%b done=%b, want 0 0 0", bus_even.busy, bus_even.bit_ready, bus_even.done); end
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         bit_in = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bus_even.done !== 1'b0 || bus_even.bit_ready !== 1'b0) bad++;
      end
      bit_valid = 1'b0;
      checks++; if (bad != 0) begin fails++; $display("[TB] FAIL abort_stays_idle: %0d bad cycles, want 0", bad); end
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checks++; if (bus_even.busy !== 1'b0) begin fails++; $display("[TB] FAIL start_abort_idle: busy=%b, want 0", bus_even.busy); end
      drive_frame(8'h3C, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++; if (bus_even.parity_ok !== e.ok_even || bus_even.data_out !== e.data) begin fails++; $display("[TB] FAIL abort_next_frame: ok=%b data=%h, want %b %h", bus_even.parity_ok, bus_even.data_out, e.ok_even, e.data); end
      ack   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      ack   = 1'b0;
      start = 1'b0;
      checks++; if (bus_even.busy !== 1'b0 || bus_even.done !== 1'b0) begin fails++; $display("[TB] FAIL ack_start_idle: busy=%b done=%b, want 0 0", bus_even.busy, bus_even.done); end
      @(negedge clk);
      checks++; if (bus_even.busy !== 1'b0) begin fails++; $display("[TB] FAIL ack_start_no_queue: busy=%b, want 0", bus_even.busy); end
      drive_frame(8'h96, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++; if (bus_even.done !== 1'b1 || bus_even.data_out !== e.data) begin fails++; $display("[TB] FAIL abort_done_pre: done=%b data=%h, want 1 %h", bus_even.done, bus_even.data_out, e.data); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++; if (bus_even.done !== 1'b0 || bus_even.busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_in_done: done=%b busy=%b, want 0 0", bus_even.done, bus_even.busy); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1;
         bit_in    = 1'b1;
         @(negedge clk);
      end
      checks++; if (bus_even.data_out !== 8'h07) begin fails++; $display("[TB] FAIL midreset_pre_data: got %h, want 07", bus_even.data_out); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus_even.busy !== 1'b0 || bus_even.bit_ready !== 1'b0 || bus_even.done !== 1'b0) begin fails++; $display("[TB] FAIL midreset_flags: busy=%b ready=%b done=%b, want 0 0 0", bus_even.busy, bus_even.bit_ready, bus_even.done); end
      checks++; if (bus_even.data_out !== 8'h00 || bus_even.parity_ok !== 1'b0) begin fails++; $display("[TB] FAIL midreset_data: data=%h ok=%b, want 00 0", bus_even.data_out, bus_even.parity_ok); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus_even.busy !== 1'b0 || bus_even.bit_ready !== 1'b0) begin fails++; $display("[TB] FAIL midreset_idle_%0d: busy=%b ready=%b, want 0 0", c, bus_even.busy, bus_even.bit_ready); end
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      $display("[TB] serial_parity_checker bench starting");
      test_reset();
      test_even_pass();
      test_hold_until_ack();
      test_odd_parity();
      test_gaps();
      test_abort();
      test_reset_mid();
      checks++; if (sb.size() != 0) begin fails++; $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
